// File: rtl/window_frame_ctrl_if.sv
// SRAM read port and sliding-window pixel stream bundled for window_frame_ctrl.
// master = frame sequencer side, slave = memory/window side.
interface window_frame_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  frame_start;
    logic [DATA_WIDTH-1:0] pixel_in;
    logic                  pixel_valid;
    logic                  window_valid;

    modport master (
        output mem_rd_en, mem_addr, frame_start, pixel_in, pixel_valid,
        input  mem_rdata, window_valid
    );

    modport slave (
        input  mem_rd_en, mem_addr, frame_start, pixel_in, pixel_valid,
        output mem_rdata, window_valid
    );
endinterface

// File: rtl/window_frame_ctrl.sv
// Frame sequencer: streams one frame from a 1-cycle-latency SRAM into the window generator and
// checks the returned window count. Optional `WINDOW_CTRL_PERF_EN adds perf_cycles/perf_stalls.
module window_frame_ctrl #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned IMG_WIDTH     = 32,
    parameter int unsigned IMG_HEIGHT    = 32,
    parameter int unsigned KERNEL_SIZE   = 3,
    parameter int unsigned STRIDE        = 1,
    parameter int unsigned PADDING       = (KERNEL_SIZE - 1) / 2,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stall,
    window_frame_ctrl_if.master    bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [15:0]            win_count
`ifdef WINDOW_CTRL_PERF_EN
    ,
    output logic [31:0]            perf_cycles,
    output logic [31:0]            perf_stalls
`endif
);
    localparam int unsigned OUT_W   = (IMG_WIDTH + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
    localparam int unsigned OUT_H   = (IMG_HEIGHT + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
    localparam int unsigned EXP_WIN = OUT_W * OUT_H;
    localparam int unsigned NUM_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned TIMER_W = $clog2(DRAIN_TIMEOUT) + 1;

    localparam logic [15:0]           EXP_CNT   = 16'(EXP_WIN);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIX - 1);
    localparam logic [TIMER_W-1:0]    LAST_TICK = TIMER_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StSof, StFeed, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  rd_q;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] pix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            timer_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_q    <= rd_en;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rd_en       = 1'b0;
        done        = 1'b0;
        bus.frame_start = 1'b0;

        // Windows are counted in every busy state; the count saturates rather than wraps.
        if (state_q != StIdle && bus.window_valid && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (cnt_q > EXP_CNT) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSof;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    addr_d  = '0;
                end
            end
            StSof: begin
                bus.frame_start = 1'b1;
                state_d         = StFeed;
            end
            StFeed: begin
                if (!stall) begin
                    rd_en = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = StDrain;
                        timer_d = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                timer_d = timer_q + 1'b1;
                if (cnt_q >= EXP_CNT) begin
                    state_d = StDone;
                end else if (timer_q == LAST_TICK) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
                if (cnt_q != EXP_CNT) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // SRAM data already arrives registered, so it only needs gating to line up with pixel_valid.
    assign pix             = rd_q ? bus.mem_rdata : '0;
    assign bus.pixel_in    = pix;
    assign bus.pixel_valid = rd_q;
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_addr    = addr_q;
    assign busy            = (state_q != StIdle);
    assign err             = err_q;
    assign win_count       = cnt_q;

`ifdef WINDOW_CTRL_PERF_EN
    logic [31:0] cyc_q, stl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            stl_q <= '0;
        end else if (state_q == StIdle) begin
            if (start) begin
                cyc_q <= '0;
                stl_q <= '0;
            end
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (state_q == StFeed && stall) begin
                stl_q <= stl_q + 32'd1;
            end
        end
    end

    assign perf_cycles = cyc_q;
    assign perf_stalls = stl_q;
`endif
endmodule

// File: tb/tb_window_frame_ctrl.sv
// Directed self-checking bench for window_frame_ctrl: SRAM model, echoing window stub and a
// second stride-2 instance for the expected-window-count boundary.
module tb_window_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        start2 = 1'b0;
    logic        busy, done, err, busy2, done2, err2;
    logic [15:0] win_count, win_count2;
`ifdef WINDOW_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_stalls, perf_cycles2, perf_stalls2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    window_frame_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus ();
    window_frame_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus2 ();

    window_frame_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .bus(bus),
        .busy(busy), .done(done), .err(err), .win_count(win_count)
`ifdef WINDOW_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    window_frame_ctrl #(.STRIDE(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .stall(1'b0), .bus(bus2),
        .busy(busy2), .done(done2), .err(err2), .win_count(win_count2)
`ifdef WINDOW_CTRL_PERF_EN
        , .perf_cycles(perf_cycles2), .perf_stalls(perf_stalls2)
`endif
    );

    // SRAM[i] = i+1 mod 256, one cycle read latency
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= 8'(bus.mem_addr + 10'd1);
        if (bus2.mem_rd_en) bus2.mem_rdata <= 8'(bus2.mem_addr + 10'd1);
    end

    // Window stub: one window per pixel, up to a per-frame limit
    logic win_on = 1'b1;
    int   win_base = 0, win_lim = 1024, win_sent = 0;
    int   win2_base = 0, win2_lim = 256, win2_sent = 0;
    always @(posedge clk) begin
        if (bus.window_valid) win_sent <= win_sent + 1;
        if (bus2.window_valid) win2_sent <= win2_sent + 1;
    end
    assign bus.window_valid  = win_on && bus.pixel_valid && (win_sent - win_base < win_lim);
    assign bus2.window_valid = bus2.pixel_valid && (win2_sent - win2_base < win2_lim);

    // Stream monitor for the main instance
    int         cyc = 0, fs_cnt = 0, done_cnt = 0, order_err = 0, frame_pix = 0;
    int         fs_cyc = 0, pv_lat = 0, last_pv_cyc = 0, done_cyc = 0;
    logic [7:0] exp_pix = 8'd1;
    always @(negedge clk) begin
        cyc++;
        if (bus.frame_start) begin
            fs_cnt++;
            fs_cyc    = cyc;
            frame_pix = 0;
            exp_pix   = 8'd1;
        end
        if (bus.pixel_valid) begin
            if (frame_pix == 0) pv_lat = cyc - fs_cyc;
            if (bus.pixel_in !== exp_pix) order_err++;
            exp_pix++;
            frame_pix++;
            last_pv_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic wait_done2(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done2) seen = 1'b1;
        end
    endtask

    task automatic wait_addr(input logic [9:0] a, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (bus.mem_addr == a && bus.mem_rd_en) hit = 1'b1;
        end
    endtask

    // Returns at the negedge of the SOF cycle
    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (win_count !== 16'd0) begin errors++; $display("FAIL reset_wc: got %0d want 0", win_count); end
        checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", bus.mem_rd_en); end
        checks++; if (bus.mem_addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.mem_addr); end
        checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", bus.frame_start); end
        checks++; if (bus.pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_pv: got %b want 0", bus.pixel_valid); end
        checks++; if (bus.pixel_in !== 8'd0) begin errors++; $display("FAIL reset_pix: got %0d want 0", bus.pixel_in); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_frame;
        int fs0 = fs_cnt, d0 = done_cnt, o0 = order_err;
        bit seen;
        win_on = 1'b1; win_base = win_sent; win_lim = 1024; stall = 1'b0;
        pulse_start;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sof_busy: got %b want 1", busy); end
        checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL sof_fs: got %b want 1", bus.frame_start); end
        checks++; if (bus.mem_addr !== 10'd0) begin errors++; $display("FAIL sof_addr: got %0d want 0", bus.mem_addr); end
        wait_done(1500, seen);
        checks++; if (!seen) begin errors++; $display("FAIL frame_done_seen: got 0 want 1"); end
        @(negedge clk);
        checks++; if (fs_cnt - fs0 !== 1) begin errors++; $display("FAIL frame_fs_cnt: got %0d want 1", fs_cnt - fs0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL frame_done_cnt: got %0d want 1", done_cnt - d0); end
        checks++; if (frame_pix !== 1024) begin errors++; $display("FAIL frame_pix: got %0d want 1024", frame_pix); end
        checks++; if (order_err - o0 !== 0) begin errors++; $display("FAIL frame_order: got %0d bad want 0", order_err - o0); end
        checks++; if (pv_lat !== 2) begin errors++; $display("FAIL frame_latency: got %0d want 2", pv_lat); end
        checks++; if (win_count !== 16'd1024) begin errors++; $display("FAIL frame_wc: got %0d want 1024", win_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL frame_err: got %b want 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after: got %b want 0", busy); end
`ifdef WINDOW_CTRL_PERF_EN
        checks++; if (perf_cycles !== 32'(done_cyc - fs_cyc + 1)) begin errors++;
            $display("FAIL perf_cycles: got %0d want %0d", perf_cycles, done_cyc - fs_cyc + 1); end
`endif
    endtask

    task automatic test_stall;
        int o0 = order_err, issued = 0, k = 0, stalls = 0, rd_bad = 0;
        bit seen;
        win_on = 1'b1; win_base = win_sent; win_lim = 1024;
        pulse_start;
        @(negedge clk);
        while (issued < 1024) begin
            stall = (k % 3 == 2);
            if (stall) stalls++; else issued++;
            #1;
            if (bus.mem_rd_en !== !stall) rd_bad++;
            k++;
            @(negedge clk);
        end
        stall = 1'b0;
        checks++; if (rd_bad !== 0) begin errors++; $display("FAIL stall_rd_en: got %0d bad cycles want 0", rd_bad); end
        wait_done(200, seen);
        checks++; if (!seen) begin errors++; $display("FAIL stall_done_seen: got 0 want 1"); end
        @(negedge clk);
        checks++; if (frame_pix !== 1024) begin errors++; $display("FAIL stall_pix: got %0d want 1024", frame_pix); end
        checks++; if (order_err - o0 !== 0) begin errors++; $display("FAIL stall_order: got %0d bad want 0", order_err - o0); end
        checks++; if (win_count !== 16'd1024) begin errors++; $display("FAIL stall_wc: got %0d want 1024", win_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL stall_err: got %b want 0", err); end
`ifdef WINDOW_CTRL_PERF_EN
        checks++; if (perf_stalls !== 32'(stalls)) begin errors++;
            $display("FAIL perf_stalls: got %0d want %0d", perf_stalls, stalls); end
`endif
    endtask

    task automatic test_timeout;
        bit seen;
        win_on = 1'b0;
        pulse_start;
        wait_done(1500, seen);
        checks++; if (!seen) begin errors++; $display("FAIL to_done_seen: got 0 want 1"); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err); end
        checks++; if (win_count !== 16'd0) begin errors++; $display("FAIL to_wc: got %0d want 0", win_count); end
        checks++; if (done_cyc - last_pv_cyc !== 64) begin errors++;
            $display("FAIL to_drain_len: got %0d want 64", done_cyc - last_pv_cyc); end
        win_on = 1'b1; win_base = win_sent; win_lim = 1024;
        pulse_start;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", err); end
        wait_done(1500, seen);
        @(negedge clk);
        checks++; if (err !== 1'b0 || !seen) begin errors++; $display("FAIL to_next_frame: err %b seen %b want 0 1", err, seen); end
    endtask

    task automatic test_restart;
        int fs0 = fs_cnt, d0 = done_cnt;
        bit hit, seen;
        win_on = 1'b1; win_base = win_sent; win_lim = 1024;
        pulse_start;
        wait_addr(10'd100, hit);
        checks++; if (!hit) begin errors++; $display("FAIL rs_reach_100: got 0 want 1"); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (bus.mem_addr !== 10'd101) begin errors++; $display("FAIL rs_addr: got %0d want 101", bus.mem_addr); end
        wait_done(1500, seen);
        @(negedge clk);
        checks++; if (fs_cnt - fs0 !== 1) begin errors++; $display("FAIL rs_fs_cnt: got %0d want 1", fs_cnt - fs0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rs_done_cnt: got %0d want 1", done_cnt - d0); end
        checks++; if (win_count !== 16'd1024) begin errors++; $display("FAIL rs_wc: got %0d want 1024", win_count); end
    endtask

    task automatic test_reset_mid;
        int d0, o0;
        bit hit, seen;
        win_on = 1'b1; win_base = win_sent; win_lim = 1024;
        pulse_start;
        wait_addr(10'd500, hit);
        checks++; if (!hit) begin errors++; $display("FAIL rm_reach_500: got 0 want 1"); end
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
        checks++; if (bus.mem_addr !== 10'd0) begin errors++; $display("FAIL rm_addr: got %0d want 0", bus.mem_addr); end
        checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL rm_rd: got %b want 0", bus.mem_rd_en); end
        checks++; if (win_count !== 16'd0) begin errors++; $display("FAIL rm_wc: got %0d want 0", win_count); end
        checks++; if (bus.pixel_valid !== 1'b0) begin errors++; $display("FAIL rm_pv: got %b want 0", bus.pixel_valid); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rm_no_done: got %0d want %0d", done_cnt, d0); end
        o0 = order_err; win_base = win_sent;
        pulse_start;
        wait_done(1500, seen);
        @(negedge clk);
        checks++; if (frame_pix !== 1024 || order_err !== o0) begin errors++;
            $display("FAIL rm_clean_pix: got %0d pixels %0d bad want 1024 0", frame_pix, order_err - o0); end
        checks++; if (win_count !== 16'd1024 || err !== 1'b0) begin errors++;
            $display("FAIL rm_clean_wc: got %0d err %b want 1024 0", win_count, err); end
    endtask

    task automatic test_stride2;
        bit seen;
        for (int n = 0; n < 2; n++) begin
            win2_base = win2_sent; win2_lim = (n == 0) ? 256 : 255;
            @(negedge clk); start2 = 1'b1;
            @(negedge clk); start2 = 1'b0;
            wait_done2(1500, seen);
            @(negedge clk);
            checks++; if (!seen) begin errors++; $display("FAIL s2_done_seen_%0d: got 0 want 1", n); end
            checks++; if (win_count2 !== 16'(win2_lim)) begin errors++;
                $display("FAIL s2_wc_%0d: got %0d want %0d", n, win_count2, win2_lim); end
            checks++; if (err2 !== (n == 1)) begin errors++;
                $display("FAIL s2_err_%0d: got %b want %b", n, err2, n == 1); end
        end
    endtask

    initial begin
        test_reset;
        test_frame;
        test_stall;
        test_timeout;
        test_restart;
        test_reset_mid;
        test_stride2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
